// File: rtl/kbd_pkg.sv
// Shared definitions for the PS/2 keyboard-to-ASCII FIFO:
// acceptor FSM states, prefix bytes and modifier scan codes.
package kbd_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACK    = 2'd1,
        ST_DECODE = 2'd2
    } kbd_state_t;

    localparam logic [7:0] SC_BREAK  = 8'hF0;
    localparam logic [7:0] SC_EXT    = 8'hE0;
    localparam logic [7:0] SC_LSHIFT = 8'h12;
    localparam logic [7:0] SC_RSHIFT = 8'h59;
    localparam logic [7:0] SC_CAPS   = 8'h58;
    localparam logic [7:0] SC_ENTER  = 8'h5A;
    localparam logic [7:0] SC_DELETE = 8'h71;

    function automatic logic is_lower(input logic [7:0] c);
        return (c >= 8'h61) && (c <= 8'h7A);
    endfunction

endpackage

// File: rtl/kbd_ascii_fifo_if.sv
// Bus bundle for kbd_ascii_fifo: PS/2 receiver handshake plus CPU read side.
interface kbd_ascii_fifo_if #(parameter int FIFO_DEPTH = 16);

    logic [7:0]                  ps2_data;
    logic                        ps2_ready;
    logic                        nextdata_n;
    logic                        rd;
    logic [7:0]                  rd_data;
    logic                        empty;
    logic                        full;
    logic [$clog2(FIFO_DEPTH):0] count;
    logic                        overflow;
    logic                        clr_ovf;

    modport slave (
        input  ps2_data, ps2_ready, rd, clr_ovf,
        output nextdata_n, rd_data, empty, full, count, overflow
    );

    modport master (
        output ps2_data, ps2_ready, rd, clr_ovf,
        input  nextdata_n, rd_data, empty, full, count, overflow
    );

endinterface

// File: rtl/kbd_scan2ascii.sv
// Combinational PS/2 set-2 (US layout) scan code to ASCII translator.
// Returns 8'h00 for any code that has no printable/control mapping.
module kbd_scan2ascii
    import kbd_pkg::*;
(
    input  logic [7:0] code,
    input  logic       shift,
    input  logic       caps,
    input  logic       ext,
    output logic [7:0] ascii
);

    logic [15:0] w_pair;
    logic [7:0]  w_lo;
    logic [7:0]  w_hi;
    logic        w_sel_hi;
    logic [7:0]  w_ext_ascii;

    // {unshifted, shifted}; keys without a shifted form repeat the same code
    always_comb begin
        w_pair = 16'h0000;
        case (code)
            8'h1C: w_pair = {8'h61, 8'h41};
            8'h32: w_pair = {8'h62, 8'h42};
            8'h21: w_pair = {8'h63, 8'h43};
            8'h23: w_pair = {8'h64, 8'h44};
            8'h24: w_pair = {8'h65, 8'h45};
            8'h2B: w_pair = {8'h66, 8'h46};
            8'h34: w_pair = {8'h67, 8'h47};
            8'h33: w_pair = {8'h68, 8'h48};
            8'h43: w_pair = {8'h69, 8'h49};
            8'h3B: w_pair = {8'h6A, 8'h4A};
            8'h42: w_pair = {8'h6B, 8'h4B};
            8'h4B: w_pair = {8'h6C, 8'h4C};
            8'h3A: w_pair = {8'h6D, 8'h4D};
            8'h31: w_pair = {8'h6E, 8'h4E};
            8'h44: w_pair = {8'h6F, 8'h4F};
            8'h4D: w_pair = {8'h70, 8'h50};
            8'h15: w_pair = {8'h71, 8'h51};
            8'h2D: w_pair = {8'h72, 8'h52};
            8'h1B: w_pair = {8'h73, 8'h53};
            8'h2C: w_pair = {8'h74, 8'h54};
            8'h3C: w_pair = {8'h75, 8'h55};
            8'h2A: w_pair = {8'h76, 8'h56};
            8'h1D: w_pair = {8'h77, 8'h57};
            8'h22: w_pair = {8'h78, 8'h58};
            8'h35: w_pair = {8'h79, 8'h59};
            8'h1A: w_pair = {8'h7A, 8'h5A};
            8'h45: w_pair = {8'h30, 8'h29};
            8'h16: w_pair = {8'h31, 8'h21};
            8'h1E: w_pair = {8'h32, 8'h40};
            8'h26: w_pair = {8'h33, 8'h23};
            8'h25: w_pair = {8'h34, 8'h24};
            8'h2E: w_pair = {8'h35, 8'h25};
            8'h36: w_pair = {8'h36, 8'h5E};
            8'h3D: w_pair = {8'h37, 8'h26};
            8'h3E: w_pair = {8'h38, 8'h2A};
            8'h46: w_pair = {8'h39, 8'h28};
            8'h0E: w_pair = {8'h60, 8'h7E};
            8'h4E: w_pair = {8'h2D, 8'h5F};
            8'h55: w_pair = {8'h3D, 8'h2B};
            8'h54: w_pair = {8'h5B, 8'h7B};
            8'h5B: w_pair = {8'h5D, 8'h7D};
            8'h5D: w_pair = {8'h5C, 8'h7C};
            8'h4C: w_pair = {8'h3B, 8'h3A};
            8'h52: w_pair = {8'h27, 8'h22};
            8'h41: w_pair = {8'h2C, 8'h3C};
            8'h49: w_pair = {8'h2E, 8'h3E};
            8'h4A: w_pair = {8'h2F, 8'h3F};
            8'h5A: w_pair = {8'h0A, 8'h0A};
            8'h66: w_pair = {8'h08, 8'h08};
            8'h29: w_pair = {8'h20, 8'h20};
            8'h0D: w_pair = {8'h09, 8'h09};
            8'h76: w_pair = {8'h1B, 8'h1B};
            default: w_pair = 16'h0000;
        endcase
    end

    always_comb begin
        w_ext_ascii = 8'h00;
        case (code)
            SC_ENTER:  w_ext_ascii = 8'h0A;
            SC_DELETE: w_ext_ascii = 8'h7F;
            default:   w_ext_ascii = 8'h00;
        endcase
    end

    assign w_lo     = w_pair[15:8];
    assign w_hi     = w_pair[7:0];
    // Caps lock only inverts the case of letters; symbols follow shift alone
    assign w_sel_hi = is_lower(w_lo) ? (shift ^ caps) : shift;
    assign ascii    = ext ? w_ext_ascii : (w_sel_hi ? w_hi : w_lo);

endmodule

// File: rtl/kbd_ascii_fifo.sv
// PS/2 byte acceptor, scan-code decoder with modifier tracking, and an
// ASCII character FIFO read by the CPU. FIFO_DEPTH must be a power of two.
module kbd_ascii_fifo
    import kbd_pkg::*;
#(
    parameter int FIFO_DEPTH = 16
) (
    input  logic               clk,
    input  logic               clrn,
    kbd_ascii_fifo_if.slave    bus
);

    localparam int             AW        = $clog2(FIFO_DEPTH);
    localparam logic [AW:0]    DEPTH_CNT = (AW + 1)'(FIFO_DEPTH);

    kbd_state_t    r_state;
    kbd_state_t    w_state_nxt;
    logic          w_accept;
    logic          w_decode;
    logic          w_nextdata_n;

    logic [7:0]    r_code;
    logic          r_brk;
    logic          r_ext;
    logic          r_shift_l;
    logic          r_shift_r;
    logic          r_caps;
    logic [7:0]    w_ascii;
    logic          w_push;

    logic [7:0]    r_mem [FIFO_DEPTH];
    logic [AW-1:0] r_wptr;
    logic [AW-1:0] r_rptr;
    logic [AW:0]   r_count;
    logic          r_ovf;
    logic          w_empty;
    logic          w_full;
    logic          w_wr;
    logic          w_rd;

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) r_state <= ST_IDLE;
        else       r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_accept     = 1'b0;
        w_decode     = 1'b0;
        w_nextdata_n = 1'b1;
        case (r_state)
            ST_IDLE: begin
                if (bus.ps2_ready) begin
                    w_accept    = 1'b1;
                    w_state_nxt = ST_ACK;
                end
            end
            ST_ACK: begin
                w_nextdata_n = 1'b0;
                w_state_nxt  = ST_DECODE;
            end
            ST_DECODE: begin
                w_decode    = 1'b1;
                w_state_nxt = ST_IDLE;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (w_accept) r_code <= bus.ps2_data;
    end

    kbd_scan2ascii u_scan2ascii (
        .code  (r_code),
        .shift (r_shift_l | r_shift_r),
        .caps  (r_caps),
        .ext   (r_ext),
        .ascii (w_ascii)
    );

    // Prefix bytes and modifiers all translate to 8'h00, so this covers them too
    assign w_push = w_decode && !r_brk && (w_ascii != 8'h00);

    // Modifiers are only recognised in their non-extended form
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            r_brk     <= 1'b0;
            r_ext     <= 1'b0;
            r_shift_l <= 1'b0;
            r_shift_r <= 1'b0;
            r_caps    <= 1'b0;
        end else if (w_decode) begin
            if (r_code == SC_BREAK) begin
                r_brk <= 1'b1;
            end else if (r_code == SC_EXT) begin
                r_ext <= 1'b1;
            end else begin
                r_brk <= 1'b0;
                r_ext <= 1'b0;
                if (!r_ext) begin
                    if (r_code == SC_LSHIFT)           r_shift_l <= !r_brk;
                    if (r_code == SC_RSHIFT)           r_shift_r <= !r_brk;
                    if (r_code == SC_CAPS && !r_brk)   r_caps    <= !r_caps;
                end
            end
        end
    end

    assign w_empty = (r_count == '0);
    assign w_full  = (r_count == DEPTH_CNT);
    assign w_rd    = bus.rd && !w_empty;
    assign w_wr    = w_push && (!w_full || bus.rd);

    always_ff @(posedge clk) begin
        if (w_wr) r_mem[r_wptr] <= w_ascii;
    end

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
            r_ovf   <= 1'b0;
        end else begin
            if (w_wr) r_wptr <= r_wptr + 1'b1;
            if (w_rd) r_rptr <= r_rptr + 1'b1;
            case ({w_wr, w_rd})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
            // A dropped character wins over a same-cycle clear
            if (w_push && w_full && !bus.rd) r_ovf <= 1'b1;
            else if (bus.clr_ovf)            r_ovf <= 1'b0;
        end
    end

    assign bus.nextdata_n = w_nextdata_n;
    assign bus.rd_data    = w_empty ? 8'h00 : r_mem[r_rptr];
    assign bus.empty      = w_empty;
    assign bus.full       = w_full;
    assign bus.count      = r_count;
    assign bus.overflow   = r_ovf;

endmodule

// File: tb/tb_kbd_ascii_fifo.sv
// Directed bench for kbd_ascii_fifo: a table of scan bytes with expected
// FIFO occupancy/head after each, plus hand-built FIFO-limit and reset cases.
module tb_kbd_ascii_fifo;

    logic clk;
    logic clrn;

    kbd_ascii_fifo_if #(.FIFO_DEPTH(16)) u_if ();

    kbd_ascii_fifo #(.FIFO_DEPTH(16)) dut (
        .clk  (clk),
        .clrn (clrn),
        .bus  (u_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] code;
        logic       pop;
        int         cnt;
        logic [7:0] data;
    } vec_t;

    vec_t vecs[$];
    int   n_vec = 0;
    int   n_err = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic add(input logic [7:0] c, input logic p, input int n, input logic [7:0] d);
        vec_t v;
        v.code = c;
        v.pop  = p;
        v.cnt  = n;
        v.data = d;
        vecs.push_back(v);
    endtask

    // Called just after a negedge; returns just after the negedge following the push edge
    task automatic send(input logic [7:0] b, input logic rd_dec, input logic clr_dec);
        u_if.ps2_data  = b;
        u_if.ps2_ready = 1'b1;
        @(negedge clk);
        u_if.ps2_ready = 1'b0;
        chk("ack_low", u_if.nextdata_n, 1'b0);
        @(negedge clk);
        chk("ack_release", u_if.nextdata_n, 1'b1);
        u_if.rd      = rd_dec;
        u_if.clr_ovf = clr_dec;
        @(negedge clk);
        u_if.rd      = 1'b0;
        u_if.clr_ovf = 1'b0;
    endtask

    task automatic pop();
        u_if.rd = 1'b1;
        @(negedge clk);
        u_if.rd = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        u_if.ps2_data  = 8'h00;
        u_if.ps2_ready = 1'b0;
        u_if.rd        = 1'b0;
        u_if.clr_ovf   = 1'b0;
        clrn           = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_nextdata_n", u_if.nextdata_n, 1'b1);
        chk("rst_empty",      u_if.empty,      1'b1);
        chk("rst_full",       u_if.full,       1'b0);
        chk("rst_count",      u_if.count,      0);
        chk("rst_overflow",   u_if.overflow,   1'b0);
        chk("rst_rd_data",    u_if.rd_data,    8'h00);
        clrn = 1'b1;
        @(negedge clk);

        // Single make, shift-modified make and break handling
        add(8'h1C, 1, 1, 8'h61);
        add(8'h12, 0, 0, 8'h00); add(8'h1C, 1, 1, 8'h41); add(8'hF0, 0, 0, 8'h00);
        add(8'h1C, 0, 0, 8'h00); add(8'hF0, 0, 0, 8'h00); add(8'h12, 0, 0, 8'h00);
        add(8'h1C, 1, 1, 8'h61);
        // Caps lock toggles on make only; symbols ignore caps
        add(8'h58, 0, 0, 8'h00); add(8'hF0, 0, 0, 8'h00); add(8'h58, 0, 0, 8'h00);
        add(8'h12, 0, 0, 8'h00); add(8'h16, 1, 1, 8'h21); add(8'hF0, 0, 0, 8'h00);
        add(8'h12, 0, 0, 8'h00); add(8'h1C, 1, 1, 8'h41);
        add(8'h12, 0, 0, 8'h00); add(8'h1C, 1, 1, 8'h61); add(8'hF0, 0, 0, 8'h00);
        add(8'h12, 0, 0, 8'h00);
        add(8'h58, 0, 0, 8'h00); add(8'hF0, 0, 0, 8'h00); add(8'h58, 0, 0, 8'h00);
        add(8'h1C, 1, 1, 8'h61);
        // Extended codes
        add(8'hE0, 0, 0, 8'h00); add(8'h5A, 1, 1, 8'h0A); add(8'hE0, 0, 0, 8'h00);
        add(8'h75, 0, 0, 8'h00); add(8'h1C, 1, 1, 8'h61); add(8'hE0, 0, 0, 8'h00);
        add(8'h71, 1, 1, 8'h7F); add(8'hE0, 0, 0, 8'h00); add(8'hF0, 0, 0, 8'h00);
        add(8'h71, 0, 0, 8'h00); add(8'h1C, 1, 1, 8'h61);
        // Control keys, digits and punctuation with/without shift
        add(8'h0D, 1, 1, 8'h09); add(8'h29, 1, 1, 8'h20); add(8'h66, 1, 1, 8'h08);
        add(8'h76, 1, 1, 8'h1B); add(8'h5A, 1, 1, 8'h0A); add(8'h45, 1, 1, 8'h30);
        add(8'h12, 0, 0, 8'h00); add(8'h4A, 1, 1, 8'h3F); add(8'h45, 1, 1, 8'h29);
        add(8'hF0, 0, 0, 8'h00); add(8'h12, 0, 0, 8'h00); add(8'h4A, 1, 1, 8'h2F);
        add(8'h59, 0, 0, 8'h00); add(8'h52, 1, 1, 8'h22); add(8'hF0, 0, 0, 8'h00);
        add(8'h59, 0, 0, 8'h00); add(8'h52, 1, 1, 8'h27); add(8'h75, 0, 0, 8'h00);

        for (int i = 0; i < vecs.size(); i++) begin
            send(vecs[i].code, 1'b0, 1'b0);
            chk($sformatf("v%0d_count", i), u_if.count,   vecs[i].cnt);
            chk($sformatf("v%0d_data", i),  u_if.rd_data, vecs[i].data);
            if (vecs[i].pop) pop();
        end

        // Fill past capacity
        for (int i = 0; i < 16; i++) send(8'h1C, 1'b0, 1'b0);
        chk("fill16_count", u_if.count,    16);
        chk("fill16_full",  u_if.full,     1'b1);
        chk("fill16_ovf",   u_if.overflow, 1'b0);
        send(8'h1C, 1'b0, 1'b0);
        chk("fill17_count", u_if.count,    16);
        chk("fill17_ovf",   u_if.overflow, 1'b1);

        u_if.clr_ovf = 1'b1;
        @(negedge clk);
        u_if.clr_ovf = 1'b0;
        chk("clr_ovf", u_if.overflow, 1'b0);

        send(8'h1C, 1'b1, 1'b0);
        chk("full_pushpop_count", u_if.count,    16);
        chk("full_pushpop_ovf",   u_if.overflow, 1'b0);
        chk("full_pushpop_full",  u_if.full,     1'b1);

        send(8'h1C, 1'b0, 1'b1);
        chk("clr_vs_ovf", u_if.overflow, 1'b1);
        chk("clr_vs_ovf_count", u_if.count, 16);

        for (int i = 0; i < 16; i++) begin
            chk($sformatf("drain%0d_data", i), u_if.rd_data, 8'h61);
            pop();
        end
        chk("drained_empty", u_if.empty,   1'b1);
        chk("drained_data",  u_if.rd_data, 8'h00);
        chk("drained_count", u_if.count,   0);

        pop();
        chk("rd_empty_count", u_if.count, 0);
        chk("rd_empty_flag",  u_if.empty, 1'b1);

        send(8'h1C, 1'b1, 1'b0);
        chk("empty_pushpop_count", u_if.count,   1);
        chk("empty_pushpop_data",  u_if.rd_data, 8'h61);

        // Reset while the acknowledge is being driven
        u_if.ps2_data  = 8'h1C;
        u_if.ps2_ready = 1'b1;
        @(negedge clk);
        u_if.ps2_ready = 1'b0;
        chk("pre_rst_ack", u_if.nextdata_n, 1'b0);
        clrn = 1'b0;
        #1;
        chk("rst_ack_nextdata_n", u_if.nextdata_n, 1'b1);
        chk("rst_ack_count",      u_if.count,      0);
        chk("rst_ack_empty",      u_if.empty,      1'b1);
        chk("rst_ack_ovf",        u_if.overflow,   1'b0);
        @(negedge clk);
        clrn = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_ack_discard", u_if.count, 0);
        send(8'h1C, 1'b0, 1'b0);
        chk("post_rst_count", u_if.count,   1);
        chk("post_rst_data",  u_if.rd_data, 8'h61);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/kbd_ascii_fifo.md
KBD_ASCII_FIFO -- requirements
Module: kbd_ascii_fifo

Interface
REQ-001 Parameter FIFO_DEPTH, default 16, number of buffered ASCII characters; SHALL be a power of two, 2..256.
REQ-002 clk  input  1  system clock (CLOCK_50 domain, same clock as the keyboard receiver).
REQ-003 clrn  input  1  asynchronous active-low reset.
REQ-004 ps2_data  input  8  scan-code byte from the PS/2 receiver.
REQ-005 ps2_ready  input  1  PS/2 receiver holds an unread byte.
REQ-006 nextdata_n  output  1  active-low one-cycle acknowledge to the PS/2 receiver.
REQ-007 rd  input  1  CPU read strobe; one-cycle pulse pops the FIFO head.
REQ-008 rd_data  output  8  FIFO head ASCII code; 8'h00 when empty.
REQ-009 empty  output  1  FIFO holds no characters.
REQ-010 full  output  1  FIFO holds FIFO_DEPTH characters.
REQ-011 count  output  $clog2(FIFO_DEPTH)+1  current occupancy.
REQ-012 overflow  output  1  sticky flag: a character was dropped because the FIFO was full.
REQ-013 clr_ovf  input  1  clears overflow.

Function
REQ-014 Acceptor FSM states SHALL be IDLE, ACK, DECODE; IDLE->ACK when ps2_ready=1 and nextdata_n=1, latching ps2_data.
REQ-015 In ACK, nextdata_n SHALL be 0 for exactly one cycle; ACK->DECODE unconditionally; DECODE->IDLE unconditionally.
REQ-016 ps2_ready is ignored outside IDLE; byte accepted at cycle N yields nextdata_n=0 at N+1 and a FIFO push (if any) at N+2.
REQ-017 Byte 8'hF0 SHALL set break flag; 8'hE0 SHALL set extended flag; neither pushes.
REQ-018 Any other byte SHALL clear both flags after being decoded.
REQ-019 Make 8'h12 or 8'h59 SHALL set shift_l/shift_r; same codes with break flag SHALL clear them.
REQ-020 Make 8'h58 SHALL toggle caps; break 8'h58 SHALL have no effect.
REQ-021 Break codes SHALL never push.
REQ-022 Non-extended make codes SHALL map via set-2 US table: letters lowercase unless (shift XOR caps); digits/punctuation take shifted symbol only when shift; 5A->0x0A, 66->0x08, 29->0x20, 0D->0x09, 76->0x1B.
REQ-023 Extended make codes: E0 5A->0x0A, E0 71->0x7F; all other extended codes SHALL be dropped.
REQ-024 Codes mapping to 0x00 SHALL NOT push.
REQ-025 Push when full SHALL be dropped and set overflow, unless rd=1 in the same cycle, in which case both pop and push occur.
REQ-026 rd when empty SHALL be ignored; simultaneous push and rd when empty SHALL push only.
REQ-027 Simultaneous push and pop otherwise SHALL leave count unchanged.
REQ-028 clr_ovf and an overflowing push in the same cycle SHALL leave overflow=1.
REQ-029 Read/write pointers SHALL wrap modulo FIFO_DEPTH; full SHALL equal count==FIFO_DEPTH.
REQ-030 rd_data SHALL be combinational from head storage; storage contents need no reset.

Reset
REQ-031 On clrn=0, asynchronously: FSM=IDLE, nextdata_n=1, pointers=0, count=0, empty=1, full=0, overflow=0, break/extended/shift_l/shift_r/caps=0.
REQ-032 Reset during ACK SHALL return nextdata_n to 1 immediately; the latched byte SHALL be discarded.

Structure
REQ-033 FSM state encoding, prefix constants (F0, E0) and modifier scan codes SHALL reside in shared package kbd_pkg.
REQ-034 The scan-code-to-ASCII table SHALL be one combinational sub-module, kbd_scan2ascii (inputs code, shift, caps, ext; output ascii).

Verification
REQ-035 Reset, then byte 1C with ps2_ready -> nextdata_n low one cycle later, count=1, rd_data=0x61.
REQ-036 Sequence 12,1C,F0,1C,F0,12 -> exactly one push, 0x41; shift cleared afterward (next 1C -> 0x61).
REQ-037 Sequence 58,F0,58,12,16 -> caps set, shift set -> push 0x21 ('!'); then F0,12,1C -> 0x41.
REQ-038 17 makes of 1C without rd -> count=16, full=1, overflow=1; 16 rd pulses return 0x61 each, then empty=1, rd_data=0x00.
REQ-039 E0,5A then E0,75 -> one push 0x0A; E0 75 dropped; extended flag cleared.
REQ-040 Full FIFO, push and rd same cycle -> count stays 16, overflow unchanged; clrn pulse during ACK -> nextdata_n=1, count=0 at once.
